shift_rows_stream: RTL

SHIFT_ROWS_STREAM -- requirements
Module: shift_rows_stream

---
 rtl/shift_rows_stream.sv | 105 ++++++++++
 1 files changed

// File: rtl/shift_rows_stream.sv
// Streaming AES ShiftRows / InvShiftRows with a small output FIFO and a delivered-block counter.
// The permutation is applied on acceptance, so the buffer only ever holds shifted states.
module shift_rows_stream #(
  parameter int unsigned NB    = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inv,
  input  logic [32*NB-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*NB-1:0]       out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       blk_count
);

  localparam int W  = 32 * int'(NB);
  localparam int Nb = int'(NB);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DepthL = LW'(DEPTH);

  logic [W-1:0]    fwd_data;
  logic [W-1:0]    inv_data;
  logic [W-1:0]    shifted;
  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            push;
  logic            pop;

  // Byte k = 4c + r sits at bits [W-1-8k -: 8]; Nb=8 skips offset 2 on rows 2 and 3.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < Nb; c++) begin : g_col
      localparam int Off    = (Nb == 8 && r >= 2) ? r + 1 : r;
      localparam int FwdCol = (c + Off) % Nb;
      localparam int InvCol = (c + Nb - Off) % Nb;
      localparam int Dst    = W - 8 - 8 * (4 * c + r);
      localparam int SrcF   = W - 8 - 8 * (4 * FwdCol + r);
      localparam int SrcI   = W - 8 - 8 * (4 * InvCol + r);
      assign fwd_data[Dst +: 8] = in_data[SrcF +: 8];
      assign inv_data[Dst +: 8] = in_data[SrcI +: 8];
    end
  end

  assign shifted = in_inv ? inv_data : fwd_data;

  // in_ready depends only on local state, rst and flush, never on out_ready.
  assign in_ready  = (count_q < DepthL) & ~rst & ~flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data  = mem_q[rd_ptr_q];
  assign level     = count_q;
  assign blk_count = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    // A pop coincident with flush is still a delivered block.
    if (pop) cnt_d = cnt_q + CNT_W'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shifted;
  end

endmodule
